// File: rtl/vx_bank_core_req_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vx_bank_core_req_queue_pkg
// Description : Shared sizing helpers for the bank core request queue and
//               its interface (lane-index width, queue-count width).
// Revision    : 1.0 - initial release
// ============================================================================
package vx_bank_core_req_queue_pkg;

    // Lane index width; a single-lane batch still needs a 1-bit index.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Occupancy counter must represent 0..q inclusive.
    function automatic int unsigned count_width(input int unsigned q);
        return $clog2(q + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vx_bank_core_req_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : vx_bank_core_req_queue_if
// Description : Batch push side and single-lane pop side of the per-bank
//               core request queue. The queue uses the slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface vx_bank_core_req_queue_if
    import vx_bank_core_req_queue_pkg::*;
#(
    parameter int unsigned NUM_REQUESTS    = 4,
    parameter int unsigned WORD_SIZE       = 4,
    parameter int unsigned WORD_ADDR_WIDTH = 30,
    parameter int unsigned TAG_WIDTH       = 16
);
    localparam int unsigned c_tid_w = clog2_min1(NUM_REQUESTS);

    logic [NUM_REQUESTS-1:0]                 push_valid;
    logic                                    push_rw;
    logic [NUM_REQUESTS*WORD_SIZE-1:0]       push_byteen;
    logic [NUM_REQUESTS*WORD_ADDR_WIDTH-1:0] push_addr;
    logic [NUM_REQUESTS*WORD_SIZE*8-1:0]     push_data;
    logic [TAG_WIDTH-1:0]                    push_tag;
    logic                                    push_ready;

    logic                                    pop_valid;
    logic [c_tid_w-1:0]                      pop_tid;
    logic                                    pop_rw;
    logic [WORD_SIZE-1:0]                    pop_byteen;
    logic [WORD_ADDR_WIDTH-1:0]              pop_addr;
    logic [WORD_SIZE*8-1:0]                  pop_data;
    logic [TAG_WIDTH-1:0]                    pop_tag;
    logic                                    pop_ready;

    logic                                    empty;
    logic                                    full;

    modport master (
        output push_valid, push_rw, push_byteen, push_addr, push_data, push_tag,
        input  push_ready,
        input  pop_valid, pop_tid, pop_rw, pop_byteen, pop_addr, pop_data, pop_tag,
        output pop_ready,
        input  empty, full
    );

    modport slave (
        input  push_valid, push_rw, push_byteen, push_addr, push_data, push_tag,
        output push_ready,
        output pop_valid, pop_tid, pop_rw, pop_byteen, pop_addr, pop_data, pop_tag,
        input  pop_ready,
        output empty, full
    );

endinterface
`default_nettype wire

// File: rtl/vx_bank_core_req_queue_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module      : vx_bank_core_req_queue_priority_encoder
// Description : Lowest-set-bit priority encoder; index is 0 when no bit set.
// Revision    : 1.0 - initial release
// ============================================================================
module vx_bank_core_req_queue_priority_encoder #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  wire logic [N-1:0] i_data,
    output logic      [W-1:0] o_index,
    output logic              o_valid
);

    // Scan from the top down so the lowest set bit is the last to win.
    always_comb begin
        o_index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_data[i]) begin
                o_index = W'(i);
            end
        end
    end

    assign o_valid = |i_data;

endmodule
`default_nettype wire

// File: rtl/vx_bank_core_req_queue.sv
`default_nettype none
// ============================================================================
// Module      : vx_bank_core_req_queue
// Description : Per-bank batch queue. Stores whole multi-lane request batches
//               and replays them one lane per cycle, lowest lane first.
// Revision    : 1.0 - initial release
// ============================================================================
module vx_bank_core_req_queue
    import vx_bank_core_req_queue_pkg::*;
#(
    parameter int unsigned NUM_REQUESTS    = 4,
    parameter int unsigned WORD_SIZE       = 4,
    parameter int unsigned WORD_ADDR_WIDTH = 30,
    parameter int unsigned TAG_WIDTH       = 16,
    parameter int unsigned QUEUE_SIZE      = 8
) (
    input  wire logic              clk,
    input  wire logic              reset,
    vx_bank_core_req_queue_if.slave bus
);

    localparam int unsigned c_tid_w = clog2_min1(NUM_REQUESTS);
    localparam int unsigned c_ptr_w = $clog2(QUEUE_SIZE);
    localparam int unsigned c_cnt_w = count_width(QUEUE_SIZE);

    typedef struct packed {
        logic [NUM_REQUESTS-1:0]                 mask;
        logic                                    rw;
        logic [NUM_REQUESTS*WORD_SIZE-1:0]       byteen;
        logic [NUM_REQUESTS*WORD_ADDR_WIDTH-1:0] addr;
        logic [NUM_REQUESTS*WORD_SIZE*8-1:0]     data;
        logic [TAG_WIDTH-1:0]                    tag;
    } entry_t;

    entry_t                  r_mem [QUEUE_SIZE];
    logic [c_ptr_w-1:0]      r_rd_ptr;
    logic [c_ptr_w-1:0]      r_wr_ptr;
    logic [c_cnt_w-1:0]      r_count;
    logic [NUM_REQUESTS-1:0] r_done_mask;

    entry_t                  w_head;
    logic [NUM_REQUESTS-1:0] w_remaining;
    logic [NUM_REQUESTS-1:0] w_lane_bit;
    logic [c_tid_w-1:0]      w_tid;
    logic                    w_any;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_retire;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_remaining = w_head.mask & ~r_done_mask;

    generate
        if (NUM_REQUESTS > 1) begin : g_multi_lane
            vx_bank_core_req_queue_priority_encoder #(
                .N (NUM_REQUESTS),
                .W (c_tid_w)
            ) u_lane_sel (
                .i_data  (w_remaining),
                .o_index (w_tid),
                .o_valid (w_any)
            );
        end else begin : g_single_lane
            assign w_tid = '0;
            assign w_any = w_remaining[0];
        end
    endgenerate

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_cnt_w'(QUEUE_SIZE));
    assign w_lane_bit = NUM_REQUESTS'(1) << w_tid;

    // No pop-through: acceptance depends only on registered occupancy.
    assign w_push   = !w_full && (|bus.push_valid);
    assign w_pop    = bus.pop_valid && bus.pop_ready;
    assign w_retire = w_pop && ((w_remaining & ~w_lane_bit) == '0);

    assign bus.push_ready = !w_full;
    assign bus.empty      = w_empty;
    assign bus.full       = w_full;
    assign bus.pop_valid  = !w_empty && w_any;
    assign bus.pop_tid    = w_tid;
    assign bus.pop_rw     = w_head.rw;
    assign bus.pop_tag    = w_head.tag;
    assign bus.pop_byteen = w_head.byteen[w_tid*WORD_SIZE +: WORD_SIZE];
    assign bus.pop_addr   = w_head.addr[w_tid*WORD_ADDR_WIDTH +: WORD_ADDR_WIDTH];
    assign bus.pop_data   = w_head.data[w_tid*WORD_SIZE*8 +: WORD_SIZE*8];

    // Batch storage; cleared on reset so the head fields are never X.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= '{mask:   bus.push_valid,
                                 rw:     bus.push_rw,
                                 byteen: bus.push_byteen,
                                 addr:   bus.push_addr,
                                 data:   bus.push_data,
                                 tag:    bus.push_tag};
        end
    end

    // Pointers, occupancy and per-lane progress of the head batch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_done_mask <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_retire) begin
                r_rd_ptr    <= r_rd_ptr + c_ptr_w'(1);
                r_done_mask <= '0;
            end else if (w_pop) begin
                r_done_mask <= r_done_mask | w_lane_bit;
            end
            case ({w_push, w_retire})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vx_bank_core_req_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_vx_bank_core_req_queue
// Description : Scoreboard bench for the per-bank core request queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vx_bank_core_req_queue;

    logic clk;
    logic reset;

    vx_bank_core_req_queue_if #(
        .NUM_REQUESTS(4), .WORD_SIZE(4), .WORD_ADDR_WIDTH(30), .TAG_WIDTH(16)
    ) bus ();

    vx_bank_core_req_queue #(
        .NUM_REQUESTS(4), .WORD_SIZE(4), .WORD_ADDR_WIDTH(30),
        .TAG_WIDTH(16), .QUEUE_SIZE(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  tid;
        logic        rw;
        logic [3:0]  byteen;
        logic [29:0] addr;
        logic [31:0] data;
        logic [15:0] tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // Per-lane field values are fixed functions of tag and lane.
    function automatic logic [29:0] lane_addr(input logic [15:0] tag, input int lane);
        return 30'(tag) * 30'd256 + 30'(lane);
    endfunction
    function automatic logic [31:0] lane_data(input logic [15:0] tag, input int lane);
        return 32'hA000_0000 | (32'(tag) << 8) | 32'(lane);
    endfunction
    function automatic logic [3:0] lane_byteen(input int lane);
        return 4'(lane + 1);
    endfunction

    // Monitor: every pop handshake is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!reset && bus.pop_valid && bus.pop_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pop: got tid %0d tag %0h, required none", bus.pop_tid, bus.pop_tag);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pop", 128'({bus.pop_tid, bus.pop_rw, bus.pop_byteen, bus.pop_addr, bus.pop_data, bus.pop_tag}),
                             128'({e.tid, e.rw, e.byteen, e.addr, e.data, e.tag}));
            end
        end
    end

    // Called at posedge+1; drives one batch across the next clock edge.
    task automatic push_batch(input logic [3:0] mask, input logic [15:0] tag, output bit accepted);
        bus.push_valid = mask;
        bus.push_rw    = tag[0];
        bus.push_tag   = tag;
        for (int i = 0; i < 4; i++) begin
            bus.push_byteen[i*4 +: 4]   = lane_byteen(i);
            bus.push_addr[i*30 +: 30]   = lane_addr(tag, i);
            bus.push_data[i*32 +: 32]   = lane_data(tag, i);
        end
        accepted = bus.push_ready && (|mask);
        if (accepted) begin
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) sb.push_back('{2'(i), tag[0], lane_byteen(i), lane_addr(tag, i), lane_data(tag, i), tag});
            end
        end
        @(posedge clk); #1;
        bus.push_valid = '0;
    endtask

    task automatic drain(input string name);
        int k;
        for (k = 0; k < 200; k++) begin
            if (sb.size() == 0 && bus.empty) break;
            @(posedge clk); #1;
        end
        check(name, 128'({bus.empty, bus.pop_valid, k < 200}), 128'(3'b101));
    endtask

    initial begin
        bit acc;
        reset           = 1'b1;
        bus.push_valid  = '0;
        bus.push_rw     = 1'b0;
        bus.push_byteen = '0;
        bus.push_addr   = '0;
        bus.push_data   = '0;
        bus.push_tag    = '0;
        bus.pop_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 128'({bus.pop_valid, bus.push_ready, bus.empty, bus.full}), 128'(4'b0110));
        reset = 1'b0;
        @(posedge clk); #1;

        // Single batch, lanes 1 and 3.
        bus.pop_ready = 1'b1;
        push_batch(4'b1010, 16'h005A, acc);
        check("single_first", 128'({bus.pop_valid, bus.pop_tid, bus.pop_tag}), 128'({1'b1, 2'd1, 16'h005A}));
        drain("single_drain");

        // All-zero mask leaves the queue untouched.
        push_batch(4'b0000, 16'h0011, acc);
        check("zero_mask", 128'({bus.empty, bus.pop_valid, bus.push_ready}), 128'(3'b101));

        // Fill eight batches with no pops.
        bus.pop_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_batch(4'b1111, 16'(16'h0010 + i), acc);
        check("fill_full", 128'({bus.full, bus.push_ready, bus.empty}), 128'(3'b100));
        push_batch(4'b1111, 16'h0077, acc);
        check("ninth_rejected", 128'({acc, bus.full, bus.pop_tid, bus.pop_tag}), 128'({1'b0, 1'b1, 2'd0, 16'h0010}));

        // Retire the head while full; a concurrent push is still refused.
        bus.pop_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("retire_last_lane", 128'({bus.pop_tid, bus.full}), 128'({2'd3, 1'b1}));
        push_batch(4'b1111, 16'h0099, acc);
        check("full_retire", 128'({acc, bus.push_ready, bus.full}), 128'(3'b010));
        drain("fill_drain");

        // Backpressure: head lane fields hold while pop_ready is low.
        bus.pop_ready = 1'b0;
        push_batch(4'b0110, 16'h0033, acc);
        for (int c = 0; c < 3; c++) begin
            check("backpressure_hold", 128'({bus.pop_valid, bus.pop_tid, bus.pop_addr}), 128'({1'b1, 2'd1, 30'h3301}));
            @(posedge clk); #1;
        end
        bus.pop_ready = 1'b1;
        drain("backpressure_drain");

        // Asynchronous reset in the middle of a three-lane batch.
        push_batch(4'b1011, 16'h0044, acc);
        @(posedge clk); #1;
        bus.pop_ready = 1'b0;
        check("mid_batch_tid", 128'({bus.pop_valid, bus.pop_tid}), 128'({1'b1, 2'd1}));
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 128'({bus.pop_valid, bus.empty, bus.push_ready, bus.full}), 128'(4'b0110));
        sb.delete();
        @(posedge clk); #1;
        reset         = 1'b0;
        bus.pop_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        check("post_reset_idle", 128'({bus.pop_valid, bus.empty}), 128'(2'b01));

        // Reuse after reset.
        push_batch(4'b1000, 16'h0066, acc);
        check("post_reset_push", 128'({bus.pop_valid, bus.pop_tid, bus.pop_data}), 128'({1'b1, 2'd3, 32'hA000_6603}));
        drain("final_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
